// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared widths, fetch FSM states and fault instruction constant.
package instr_fetch_unit_pkg;

    localparam int DEF_MEM_ADDR_WIDTH = 32;
    localparam int DEF_INSTR_WIDTH    = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_REQ,
        IF_WAIT,
        IF_DROP
    } if_state_t;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// fetch_queue: 2-entry shift FIFO of {misaligned, pc, instr}; flush beats push and pop.
module fetch_queue #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] e0, e1;

    always_ff @(posedge clk) begin
        if (rst || flush)
            count <= '0;
        else
            count <= count + {1'b0, push} - {1'b0, pop};
        // entry 0 is always the head; popping shifts entry 1 forward
        if (pop)
            e0 <= (push && count == 2'd1) ? din : e1;
        else if (push && count == 2'd0)
            e0 <= din;
        if (push && (count == 2'd2 || (count == 2'd1 && !pop)))
            e1 <= din;
    end

    assign head = e0;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues one word read per PC over req/gnt/rvalid and queues
// returned instructions with their PCs for decode; supports flush and misaligned faults.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int INSTR_WIDTH    = DEF_INSTR_WIDTH,
    parameter int QUEUE_DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MEM_ADDR_WIDTH-1:0] pc_i,
    output logic                      pc_advance_o,
    input  logic                      flush_i,
    output logic                      imem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                      imem_gnt_i,
    input  logic                      imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0]    imem_rdata_i,
    output logic                      instr_valid_o,
    input  logic                      instr_ready_i,
    output logic [INSTR_WIDTH-1:0]    instr_o,
    output logic [MEM_ADDR_WIDTH-1:0] instr_pc_o,
    output logic                      instr_misaligned_o
);

    localparam int EW = 1 + MEM_ADDR_WIDTH + INSTR_WIDTH;
    localparam logic [1:0] DEPTH = 2'(QUEUE_DEPTH);

    if_state_t                 state, state_next;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_next;
    logic                      flush_seen, flush_seen_next;
    logic                      push, pop, aligned, flushed;
    logic [EW-1:0]             push_data, head;
    logic [1:0]                count;

    fetch_queue #(.W(EW)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .head  (head),
        .count (count)
    );

    assign aligned       = word_aligned(pc_i[1:0]);
    assign flushed       = flush_i || flush_seen;
    assign instr_valid_o = count != 2'd0;
    assign pop           = instr_valid_o && instr_ready_i;
    assign imem_req_o    = state == IF_REQ;
    assign imem_addr_o   = addr_q;
    assign {instr_misaligned_o, instr_pc_o, instr_o} = instr_valid_o ? head : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IF_IDLE;
            addr_q     <= '0;
            flush_seen <= 1'b0;
        end else begin
            state      <= state_next;
            addr_q     <= addr_next;
            flush_seen <= flush_seen_next;
        end
    end

    always_comb begin
        state_next      = state;
        addr_next       = addr_q;
        flush_seen_next = flush_seen;
        push            = 1'b0;
        push_data       = {1'b0, addr_q, imem_rdata_i};
        pc_advance_o    = 1'b0;
        case (state)
            IF_IDLE: begin
                if (count < DEPTH && !flush_i) begin
                    if (aligned) begin
                        addr_next  = pc_i;
                        state_next = IF_REQ;
                    end else begin
                        push         = 1'b1;
                        push_data    = {1'b1, pc_i, INSTR_WIDTH'(NOP_INSTR)};
                        pc_advance_o = 1'b1;
                    end
                end
            end
            IF_REQ: begin
                // the request stays up until granted; a flush only turns the response into a drop
                if (imem_gnt_i) begin
                    pc_advance_o    = !flushed;
                    state_next      = flushed ? IF_DROP : IF_WAIT;
                    flush_seen_next = 1'b0;
                end else begin
                    flush_seen_next = flushed;
                end
            end
            IF_WAIT: begin
                if (imem_rvalid_i) begin
                    push       = !flush_i;
                    addr_next  = pc_i;
                    state_next = (!flush_i && aligned && count + 2'd1 - {1'b0, pop} < DEPTH)
                                 ? IF_REQ : IF_IDLE;
                end else if (flush_i) begin
                    state_next = IF_DROP;
                end
            end
            IF_DROP: state_next = imem_rvalid_i ? IF_IDLE : IF_DROP;
            default: state_next = IF_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: per-cycle directed vectors with hand-computed expectations.
module tb_instr_fetch_unit;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        flush, gnt, rvalid;
        logic [31:0] rdata;
        logic        ready, chk, req;
        logic [31:0] addr;
        logic        adv, valid;
        logic [31:0] instr, ipc;
        logic        mis;
    } vec_t;

    logic        clk = 1'b1;
    logic        rst, flush_i, imem_gnt_i, imem_rvalid_i, instr_ready_i;
    logic [31:0] pc_i, imem_rdata_i;
    logic        pc_advance_o, imem_req_o, instr_valid_o, instr_misaligned_o;
    logic [31:0] imem_addr_o, instr_o, instr_pc_o;

    int n_checks = 0;
    int n_fail   = 0;
    int row      = 0;
    logic last_rst = 1'b0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk                (clk),
        .rst                (rst),
        .pc_i               (pc_i),
        .pc_advance_o       (pc_advance_o),
        .flush_i            (flush_i),
        .imem_req_o         (imem_req_o),
        .imem_addr_o        (imem_addr_o),
        .imem_gnt_i         (imem_gnt_i),
        .imem_rvalid_i      (imem_rvalid_i),
        .imem_rdata_i       (imem_rdata_i),
        .instr_valid_o      (instr_valid_o),
        .instr_ready_i      (instr_ready_i),
        .instr_o            (instr_o),
        .instr_pc_o         (instr_pc_o),
        .instr_misaligned_o (instr_misaligned_o)
    );

    function automatic vec_t v(
        input logic [31:0] r, pc, fl, g, rv, rd, rdy, ck, eq, ea, eadv, ev, ei, eip, em
    );
        vec_t x;
        x.rst = r[0]; x.pc = pc; x.flush = fl[0]; x.gnt = g[0]; x.rvalid = rv[0];
        x.rdata = rd; x.ready = rdy[0]; x.chk = ck[0]; x.req = eq[0]; x.addr = ea;
        x.adv = eadv[0]; x.valid = ev[0]; x.instr = ei; x.ipc = eip; x.mis = em[0];
        return x;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        rst = x.rst; pc_i = x.pc; flush_i = x.flush; imem_gnt_i = x.gnt;
        imem_rvalid_i = x.rvalid; imem_rdata_i = x.rdata; instr_ready_i = x.ready;
        @(negedge clk);
        if (x.chk) begin
            cmp("imem_req_o", {31'b0, imem_req_o}, {31'b0, x.req});
            if (x.req || last_rst)
                cmp("imem_addr_o", imem_addr_o, x.addr);
            cmp("pc_advance_o", {31'b0, pc_advance_o}, {31'b0, x.adv});
            cmp("instr_valid_o", {31'b0, instr_valid_o}, {31'b0, x.valid});
            cmp("instr_o", instr_o, x.instr);
            cmp("instr_pc_o", instr_pc_o, x.ipc);
            cmp("instr_misaligned_o", {31'b0, instr_misaligned_o}, {31'b0, x.mis});
        end
        last_rst = x.rst;
        @(posedge clk);
        #1;
        row++;
    endtask

    initial begin
        // reset, first fetch, then fill the queue with decode stalled
        tbl.push_back(v(1, 0,     0, 0, 0, 0,           0, 0, 0, 0,     0, 0, 0,           0,     0));
        tbl.push_back(v(0, 0,     0, 0, 0, 0,           0, 1, 0, 0,     0, 0, 0,           0,     0));
        tbl.push_back(v(0, 0,     0, 1, 0, 0,           0, 1, 1, 0,     1, 0, 0,           0,     0));
        tbl.push_back(v(0, 'h4,   0, 0, 1, 'h00500093,  0, 1, 0, 0,     0, 0, 0,           0,     0));
        tbl.push_back(v(0, 'h4,   0, 1, 0, 0,           0, 1, 1, 'h4,   1, 1, 'h00500093,  0,     0));
        tbl.push_back(v(0, 'h8,   0, 0, 1, 'h00a00113,  0, 1, 0, 0,     0, 1, 'h00500093,  0,     0));
        tbl.push_back(v(0, 'h8,   0, 0, 0, 0,           0, 1, 0, 0,     0, 1, 'h00500093,  0,     0));
        tbl.push_back(v(0, 'h8,   0, 0, 0, 0,           0, 1, 0, 0,     0, 1, 'h00500093,  0,     0));
        tbl.push_back(v(0, 'h8,   0, 0, 0, 0,           1, 1, 0, 0,     0, 1, 'h00500093,  0,     0));
        tbl.push_back(v(0, 'h8,   0, 0, 0, 0,           0, 1, 0, 0,     0, 1, 'h00a00113,  'h4,   0));
        tbl.push_back(v(0, 'h8,   0, 1, 0, 0,           0, 1, 1, 'h8,   1, 1, 'h00a00113,  'h4,   0));
        tbl.push_back(v(0, 'hc,   0, 0, 1, 'h00000013,  1, 1, 0, 0,     0, 1, 'h00a00113,  'h4,   0));
        tbl.push_back(v(0, 'hc,   0, 0, 0, 0,           1, 1, 1, 'hc,   0, 1, 'h00000013,  'h8,   0));
        tbl.push_back(v(0, 'hc,   0, 1, 0, 0,           0, 1, 1, 'hc,   1, 0, 0,           0,     0));
        tbl.push_back(v(0, 'h10,  0, 0, 1, 'h11111111,  0, 1, 0, 0,     0, 0, 0,           0,     0));
        // grant held off for three cycles at 0x10
        tbl.push_back(v(0, 'h10,  0, 0, 0, 0,           1, 1, 1, 'h10,  0, 1, 'h11111111,  'hc,   0));
        tbl.push_back(v(0, 'h10,  0, 0, 0, 0,           0, 1, 1, 'h10,  0, 0, 0,           0,     0));
        tbl.push_back(v(0, 'h10,  0, 0, 0, 0,           0, 1, 1, 'h10,  0, 0, 0,           0,     0));
        tbl.push_back(v(0, 'h10,  0, 1, 0, 0,           0, 1, 1, 'h10,  1, 0, 0,           0,     0));
        tbl.push_back(v(0, 'h14,  0, 0, 1, 'h22222222,  0, 1, 0, 0,     0, 0, 0,           0,     0));
        tbl.push_back(v(0, 'h14,  0, 1, 0, 0,           0, 1, 1, 'h14,  1, 1, 'h22222222,  'h10,  0));
        foreach (tbl[i]) apply(tbl[i]);

        // flush while waiting: late data dropped, queue cleared, redirected PC fetched
        apply(v(0, 'h18,  1, 0, 0, 0,           0, 1, 0, 0,     0, 1, 'h22222222,  'h10,  0));
        apply(v(0, 'h100, 0, 0, 1, 'hdeadbeef,  0, 1, 0, 0,     0, 0, 0,           0,     0));
        apply(v(0, 'h100, 0, 0, 0, 0,           0, 1, 0, 0,     0, 0, 0,           0,     0));
        apply(v(0, 'h100, 0, 1, 0, 0,           0, 1, 1, 'h100, 1, 0, 0,           0,     0));
        apply(v(0, 'h104, 0, 0, 1, 'h33333333,  0, 1, 0, 0,     0, 0, 0,           0,     0));
        apply(v(0, 'h104, 0, 0, 0, 0,           1, 1, 1, 'h104, 0, 1, 'h33333333,  'h100, 0));
        // flush before grant: request held, no advance on the grant, response dropped
        apply(v(0, 'h104, 1, 0, 0, 0,           0, 1, 1, 'h104, 0, 0, 0,           0,     0));
        apply(v(0, 'h200, 0, 1, 0, 0,           0, 1, 1, 'h104, 0, 0, 0,           0,     0));
        apply(v(0, 'h200, 0, 0, 1, 'h44444444,  0, 1, 0, 0,     0, 0, 0,           0,     0));
        // misaligned PC: fault entry, advance, no memory request
        apply(v(0, 'h206, 0, 0, 0, 0,           0, 1, 0, 0,     1, 0, 0,           0,     0));
        apply(v(0, 'h208, 0, 0, 0, 0,           0, 1, 0, 0,     0, 1, 0,           'h206, 1));
        apply(v(0, 'h208, 0, 0, 0, 0,           0, 1, 1, 'h208, 0, 1, 0,           'h206, 1));
        // reset while in REQ with one queued entry
        apply(v(1, 'h208, 0, 0, 0, 0,           0, 1, 1, 'h208, 0, 1, 0,           'h206, 1));
        apply(v(0, 0,     0, 0, 0, 0,           0, 1, 0, 0,     0, 0, 0,           0,     0));
        // flush coinciding with rvalid: data discarded, FSM returns to IDLE
        apply(v(0, 0,     0, 1, 0, 0,           0, 1, 1, 0,     1, 0, 0,           0,     0));
        apply(v(0, 'h4,   1, 0, 1, 'h55555555,  0, 1, 0, 0,     0, 0, 0,           0,     0));
        apply(v(0, 'h40,  0, 0, 0, 0,           0, 1, 0, 0,     0, 0, 0,           0,     0));
        apply(v(0, 'h40,  0, 0, 0, 0,           0, 1, 1, 'h40,  0, 0, 0,           0,     0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
